pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 165 ++++++++++++++++
 tb/tb_pipe_adder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder -- chunked ripple-carry adder spread over STAGES pipeline stages.
//
// Stage k adds operand chunk k (CHUNK = WIDTH/STAGES bits) plus the carry
// registered by stage k-1. The operand bits still to be added and the sum bits
// already produced travel with the transaction, so one transaction's chunks
// stay together. A single advance enable stalls the whole pipe when the output
// holds a result that downstream has not taken.
//
// Parameters
//   WIDTH   operand / sum width in bits (>= 2)
//   STAGES  pipeline depth; WIDTH must be a multiple of STAGES
//
// Ports
//   sys_clk    in   clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   in1, in2   in   unsigned operands            [WIDTH]
//   cin        in   carry-in
//   in_valid   in   operands valid this cycle
//   in_ready   out  operands accepted this cycle (combinational)
//   sum        out  (in1 + in2 + cin) mod 2^WIDTH [WIDTH]
//   cout       out  carry out of bit WIDTH-1
//   ovf        out  signed overflow of the same transaction
//                   (present only when PIPE_ADDER_OVF_EN is defined)
//   out_valid  out  sum/cout hold a valid result
//   out_ready  in   downstream accepts the result
//
// Build option: define PIPE_ADDER_OVF_EN to add the ovf output.
// -----------------------------------------------------------------------------
module pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid,
`ifdef PIPE_ADDER_OVF_EN
    output logic             ovf,
`endif
    input  logic             out_ready
);

    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end

`ifdef PIPE_ADDER_OVF_EN
    // Two's-complement overflow: like-signed operands giving an unlike-signed sum.
    function automatic logic sgn_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction
`endif

    logic                adv;
    logic [STAGES-1:0]   vld_p;
    logic [STAGES-1:0]   cy_p;
    logic [STAGES-1:0]   cy_n;
    // Operand registers are kept shifted so the next chunk to add is always
    // in the low CHUNK bits; sum registers fill from the top, one chunk per
    // stage, so the final stage holds the sum in natural bit order.
    logic [WIDTH-1:0]    opa_p [STAGES];
    logic [WIDTH-1:0]    opb_p [STAGES];
    logic [WIDTH-1:0]    sum_p [STAGES];
    logic [WIDTH-1:0]    opa_n [STAGES];
    logic [WIDTH-1:0]    opb_n [STAGES];
    logic [WIDTH-1:0]    sum_n [STAGES];
`ifdef PIPE_ADDER_OVF_EN
    logic                ovf_n;
    logic                ovf_p;
`endif

    // Any slot may move only if the output slot is empty or being drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] s_i;
        logic             c_i;
        logic [CHUNK:0]   part;

        if (k == 0) begin : g_first
            assign a_i = in1;
            assign b_i = in2;
            assign s_i = '0;
            assign c_i = cin;
        end else begin : g_rest
            assign a_i = opa_p[k-1];
            assign b_i = opb_p[k-1];
            assign s_i = sum_p[k-1];
            assign c_i = cy_p[k-1];
        end

        assign part     = {1'b0, a_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]}
                        + {{CHUNK{1'b0}}, c_i};
        assign cy_n[k]  = part[CHUNK];
        assign opa_n[k] = a_i >> CHUNK;
        assign opb_n[k] = b_i >> CHUNK;
        assign sum_n[k] = (s_i >> CHUNK) | (WIDTH'(part[CHUNK-1:0]) << (WIDTH - CHUNK));

`ifdef PIPE_ADDER_OVF_EN
        // The last stage sees the top operand chunk and produces the sum MSB.
        if (k == STAGES - 1) begin : g_ovf
            assign ovf_n = sgn_ovf(a_i[CHUNK-1], b_i[CHUNK-1], part[CHUNK-1]);
        end
`endif
    end

    // ---- stage boundary: valid, carry and partial-sum registers ----
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_p <= '0;
            cy_p  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                sum_p[k] <= '0;
            end
        end else if (adv) begin
            // Bubbles enter as invalid slots; nothing is compressed.
            vld_p <= (vld_p << 1) | STAGES'(in_valid);
            cy_p  <= cy_n;
            for (int k = 0; k < STAGES; k++) begin
                sum_p[k] <= sum_n[k];
            end
        end
    end

    // ---- stage boundary: operand skew registers (data only, no reset) ----
    always_ff @(posedge sys_clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                opa_p[k] <= opa_n[k];
                opb_p[k] <= opb_n[k];
            end
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    // ---- stage boundary: overflow flag, aligned with the final sum ----
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ovf_p <= 1'b0;
        end else if (adv) begin
            ovf_p <= ovf_n;
        end
    end

    assign ovf = ovf_p;
`endif

    assign out_valid = vld_p[STAGES-1];
    assign cout      = cy_p[STAGES-1];
    assign sum       = sum_p[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder -- three pipe_adder instances (16/4, 8/1, 32/8) driven with
// shared stimulus. Each instance has a queue-based reference: accepted
// transactions age by one on every advancing edge and become visible once
// they are STAGES-1 edges old. A per-instance compare process checks outputs
// on every falling edge; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

    logic        sys_clk;
    logic        rst_n;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        cin;
    logic        in_valid;
    logic        out_ready;

    logic [31:0] sum_w [3];
    logic [2:0]  cout_w;
    logic [2:0]  ovld_w;
    logic [2:0]  irdy_w;
`ifdef PIPE_ADDER_OVF_EN
    logic [2:0]  ovf_w;
`endif

    int n_tot;
    int n_pass;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int W = (g == 0) ? 16 : (g == 1) ? 8 : 32;
        localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : 8;
        localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

        logic [W-1:0] sum_o;
        logic         cout_o;
        logic         ovld_o;
        logic         irdy_o;
`ifdef PIPE_ADDER_OVF_EN
        logic         ovf_o;
`endif

        pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
            .sys_clk   (sys_clk),
            .sys_rst_n (rst_n),
            .in1       (in1[W-1:0]),
            .in2       (in2[W-1:0]),
            .cin       (cin),
            .in_valid  (in_valid),
            .in_ready  (irdy_o),
            .sum       (sum_o),
            .cout      (cout_o),
            .out_valid (ovld_o),
`ifdef PIPE_ADDER_OVF_EN
            .ovf       (ovf_o),
`endif
            .out_ready (out_ready)
        );

        assign sum_w[g]  = 32'(sum_o);
        assign cout_w[g] = cout_o;
        assign ovld_w[g] = ovld_o;
        assign irdy_w[g] = irdy_o;
`ifdef PIPE_ADDER_OVF_EN
        assign ovf_w[g]  = ovf_o;
`endif

        longint unsigned val_q[$];
        int              age_q[$];
        longint unsigned ma, mb;
        bit              hd;
        bit              ev;
`ifdef PIPE_ADDER_OVF_EN
        bit              ovf_q[$];
        longint          sa, sb, ss;
`endif

        // Reference: fixed latency, whole pipe frozen while the head waits.
        initial forever begin
            @(posedge sys_clk or negedge rst_n);
            if (!rst_n) begin
                val_q.delete();
                age_q.delete();
`ifdef PIPE_ADDER_OVF_EN
                ovf_q.delete();
`endif
            end else begin
                hd = (age_q.size() > 0) && (age_q[0] == S - 1);
                if (!hd || out_ready) begin
                    if (hd) begin
                        void'(val_q.pop_front());
                        void'(age_q.pop_front());
`ifdef PIPE_ADDER_OVF_EN
                        void'(ovf_q.pop_front());
`endif
                    end
                    foreach (age_q[i]) age_q[i]++;
                    if (in_valid) begin
                        ma = 64'(in1[W-1:0]);
                        mb = 64'(in2[W-1:0]);
                        val_q.push_back(ma + mb + 64'(cin));
                        age_q.push_back(0);
`ifdef PIPE_ADDER_OVF_EN
                        sa = (ma >= (64'd1 << (W-1))) ? longint'(ma) - longint'(64'd1 << W) : longint'(ma);
                        sb = (mb >= (64'd1 << (W-1))) ? longint'(mb) - longint'(64'd1 << W) : longint'(mb);
                        ss = sa + sb + longint'(cin);
                        ovf_q.push_back((ss > longint'((64'd1 << (W-1)) - 64'd1)) ||
                                        (ss < -longint'(64'd1 << (W-1))));
`endif
                    end
                end
            end
        end

        initial forever begin
            @(negedge sys_clk);
            if (!rst_n) begin
                check($sformatf("g%0d rst out_valid", g), 64'(ovld_o), 64'd0);
                check($sformatf("g%0d rst sum", g), 64'(sum_o), 64'd0);
                check($sformatf("g%0d rst cout", g), 64'(cout_o), 64'd0);
                check($sformatf("g%0d rst in_ready", g), 64'(irdy_o), 64'd1);
`ifdef PIPE_ADDER_OVF_EN
                check($sformatf("g%0d rst ovf", g), 64'(ovf_o), 64'd0);
`endif
            end else begin
                ev = (age_q.size() > 0) && (age_q[0] == S - 1);
                check($sformatf("g%0d out_valid", g), 64'(ovld_o), 64'(ev));
                check($sformatf("g%0d in_ready", g), 64'(irdy_o), 64'(!ev || out_ready));
                if (ev) begin
                    check($sformatf("g%0d sum", g), 64'(sum_o), val_q[0] & MASK);
                    check($sformatf("g%0d cout", g), 64'(cout_o), (val_q[0] >> W) & 64'd1);
`ifdef PIPE_ADDER_OVF_EN
                    check($sformatf("g%0d ovf", g), 64'(ovf_o), 64'(ovf_q[0]));
`endif
                end
            end
        end
    end

    // Inputs change 1 time unit after the falling edge, clear of both edges.
    task automatic cyc();
        @(negedge sys_clk);
        #1;
    endtask

    initial begin
        bit seen;
        n_tot     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in1       = '0;
        in2       = '0;
        cin       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        repeat (3) cyc();
        check("lit rst out_valid", 64'(ovld_w[0]), 64'd0);
        check("lit rst sum", 64'(sum_w[0]), 64'd0);
        check("lit rst in_ready", 64'(irdy_w[0]), 64'd1);
        rst_n = 1'b1;
        cyc();
        check("lit post-rst in_ready", 64'(irdy_w[0]), 64'd1);

        // Single transaction FFFF + 0001: latency 4 / 1 / 8 on the three pipes.
        in1 = 32'h0000_FFFF; in2 = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 0) begin
                check("lit w8 lat1 valid", 64'(ovld_w[1]), 64'd1);
                check("lit w8 lat1 sum", 64'(sum_w[1]), 64'h00);
                check("lit w8 lat1 cout", 64'(cout_w[1]), 64'd1);
                in_valid = 1'b0;
            end
            if (k == 2) check("lit w16 early valid", 64'(ovld_w[0]), 64'd0);
            if (k == 3) begin
                check("lit w16 lat4 valid", 64'(ovld_w[0]), 64'd1);
                check("lit w16 lat4 sum", 64'(sum_w[0]), 64'h0000);
                check("lit w16 lat4 cout", 64'(cout_w[0]), 64'd1);
            end
            if (k == 4) check("lit w16 one-cycle valid", 64'(ovld_w[0]), 64'd0);
            if (k == 6) check("lit w32 early valid", 64'(ovld_w[2]), 64'd0);
            if (k == 7) begin
                check("lit w32 lat8 valid", 64'(ovld_w[2]), 64'd1);
                check("lit w32 lat8 sum", 64'(sum_w[2]), 64'h0001_0000);
                check("lit w32 lat8 cout", 64'(cout_w[2]), 64'd0);
            end
        end

        // Eight back-to-back random transactions.
        for (int i = 0; i < 8; i++) begin
            in1 = $urandom; in2 = $urandom; cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        repeat (12) cyc();

        // 0x1234 + 0x1111 + 1 then hold out_ready low for five cycles.
        in1 = 32'h1234; in2 = 32'h1111; cin = 1'b1; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (ovld_w[0]) seen = 1'b1;
            else cyc();
        end
        check("lit stall result arrives", 64'(seen), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("lit stall sum", 64'(sum_w[0]), 64'h2346);
            check("lit stall cout", 64'(cout_w[0]), 64'd0);
            check("lit stall out_valid", 64'(ovld_w[0]), 64'd1);
            check("lit stall in_ready", 64'(irdy_w[0]), 64'd0);
            in1 = $urandom; in2 = $urandom; in_valid = 1'b1;
            cyc();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        cyc();
        check("lit stall released", 64'(ovld_w[0]), 64'd0);
        repeat (12) cyc();

        // Asynchronous reset with transactions in flight.
        for (int i = 0; i < 3; i++) begin
            in1 = 32'h0100 + 32'(i); in2 = 32'h0001; cin = 1'b0; in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        check("lit pre-rst valid", 64'(ovld_w[0]), 64'd1);
        check("lit pre-rst sum", 64'(sum_w[0]), 64'h0101);
        #1 rst_n = 1'b0;
        #1;
        check("lit async rst valid", 64'(ovld_w[0]), 64'd0);
        check("lit async rst sum", 64'(sum_w[0]), 64'd0);
        check("lit async rst w32 sum", 64'(sum_w[2]), 64'd0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("lit no result after rst", 64'(ovld_w), 64'd0);
        end

`ifdef PIPE_ADDER_OVF_EN
        in1 = 32'h7FFF; in2 = 32'h0001; cin = 1'b0; in_valid = 1'b1;
        cyc();
        in1 = 32'hFFFF; in2 = 32'hFFFF;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        check("lit ovf1 sum", 64'(sum_w[0]), 64'h8000);
        check("lit ovf1 cout", 64'(cout_w[0]), 64'd0);
        check("lit ovf1 ovf", 64'(ovf_w[0]), 64'd1);
        cyc();
        check("lit ovf2 sum", 64'(sum_w[0]), 64'hFFFE);
        check("lit ovf2 cout", 64'(cout_w[0]), 64'd1);
        check("lit ovf2 ovf", 64'(ovf_w[0]), 64'd0);
        repeat (10) cyc();
`endif

        // Random traffic with bubbles and backpressure.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       begin in1 = 32'hFFFF_FFFF; in2 = $urandom; end
                1:       begin in1 = 32'h7FFF_7F7F; in2 = 32'h0000_8081; end
                default: begin in1 = $urandom; in2 = $urandom; end
            endcase
            cin       = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) cyc();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
